// File: rtl/icache_responder_if.sv
// Instruction-side bus of the cache: datapath fetch port, memory-controller
// fill port and the hit/miss statistics counters.
interface icache_responder_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   // Cache side: answers fetches and issues fills
   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr, hit_count, miss_count
   );

   // Datapath / memory-controller side
   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr, hit_count, miss_count
   );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally in IDLE; a miss launches a single-word
// fill that always runs to completion before returning to IDLE.
module icache_responder #(
   parameter int unsigned NSETS = 16,
   parameter int unsigned TAGW  = 32 - $clog2(NSETS) - 2
) (
   input  logic               CLK,
   input  logic               nRST,
   icache_responder_if.slave  bus
);
   localparam int unsigned IDXW = $clog2(NSETS);

   typedef enum logic {IDLE, FILL} state_e;

   state_e            state_q, state_d;
   logic [NSETS-1:0]  valid_q, valid_d;
   logic [TAGW-1:0]   tag_q  [NSETS];
   logic [31:0]       data_q [NSETS];
   logic              iren_q, iren_d;
   logic [31:0]       iaddr_q, iaddr_d;
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   logic [TAGW-1:0]   req_tag, fill_tag;
   logic [IDXW-1:0]   req_idx, fill_idx;
   logic              hit, fill_done;

   assign req_tag  = bus.imemaddr[31:IDXW+2];
   assign req_idx  = bus.imemaddr[IDXW+1:2];
   assign fill_tag = iaddr_q[31:IDXW+2];
   assign fill_idx = iaddr_q[IDXW+1:2];

   assign hit       = (state_q == IDLE) && bus.imemREN && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
   assign fill_done = (state_q == FILL) && !bus.iwait;

   // Next-state, fill request and statistics counters
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      iren_d     = iren_q;
      iaddr_d    = iaddr_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         IDLE: begin
            if (hit) begin
               hit_cnt_d = hit_cnt_q + 32'd1;
            end else if (bus.imemREN) begin
               iaddr_d    = {bus.imemaddr[31:2], 2'b00};
               iren_d     = 1'b1;
               miss_cnt_d = miss_cnt_q + 32'd1;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (!bus.iwait) begin
               valid_d[fill_idx] = 1'b1;
               iren_d            = 1'b0;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state; reset also invalidates every frame and aborts a fill
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         iren_q     <= 1'b0;
         iaddr_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         iren_q     <= iren_d;
         iaddr_q    <= iaddr_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Tag/data arrays: contents are qualified by valid_q, so no reset needed
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.iload;
      end
   end

   assign bus.ihit       = hit;
   assign bus.imemload   = hit ? data_q[req_idx] : '0;
   assign bus.iREN       = iren_q;
   assign bus.iaddr      = iaddr_q;
   assign bus.hit_count  = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_icache_responder;
   logic CLK;
   logic nRST;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   icache_responder_if bus ();

   icache_responder #(.NSETS(16)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full clock: through the rising edge to the next falling edge
   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Miss at addr, memory busy for nwait cycles, then returns data;
   // ends at the falling edge of the first hit cycle (hit not yet counted)
   task automatic do_fill(input logic [31:0] addr, input logic [31:0] data, input int unsigned nwait);
      bus.imemREN  = 1'b1;
      bus.imemaddr = addr;
      bus.iwait    = 1'b1;
      #1;
      chk("miss_ihit", {31'd0, bus.ihit}, 32'd0);
      cyc();
      for (int unsigned w = 0; w < nwait; w++) begin
         #1;
         chk("fill_iREN", {31'd0, bus.iREN}, 32'd1);
         chk("fill_iaddr", bus.iaddr, addr);
         chk("fill_ihit", {31'd0, bus.ihit}, 32'd0);
         cyc();
      end
      bus.iwait = 1'b0;
      bus.iload = data;
      #1;
      chk("last_iREN", {31'd0, bus.iREN}, 32'd1);
      chk("last_ihit", {31'd0, bus.ihit}, 32'd0);
      cyc();
      bus.iwait = 1'b1;
      bus.iload = 32'hFFFF_FFFF;
      #1;
      chk("post_ihit", {31'd0, bus.ihit}, 32'd1);
      chk("post_load", bus.imemload, data);
      chk("post_iREN", {31'd0, bus.iREN}, 32'd0);
   endtask

   initial begin
      nRST         = 1'b0;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;

      // Reset state
      @(negedge CLK);
      #1;
      chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
      chk("rst_load", bus.imemload, 32'd0);
      chk("rst_iREN", {31'd0, bus.iREN}, 32'd0);
      chk("rst_iaddr", bus.iaddr, 32'd0);
      chk("rst_hits", bus.hit_count, 32'd0);
      chk("rst_miss", bus.miss_count, 32'd0);
      cyc();
      nRST = 1'b1;
      cyc();

      // First fetch: 2 busy cycles, then data
      do_fill(32'h0000_0000, 32'h3C01_0001, 2);
      chk("t1_miss", bus.miss_count, 32'd1);
      chk("t1_hit0", bus.hit_count, 32'd0);
      cyc();
      chk("t1_hit1", bus.hit_count, 32'd1);

      // Re-fetch held at the same PC: hit every cycle, no memory access
      chk("t2_ihit", {31'd0, bus.ihit}, 32'd1);
      chk("t2_iREN", {31'd0, bus.iREN}, 32'd0);
      cyc();
      cyc();
      #1;
      chk("t2_hits", bus.hit_count, 32'd3);
      chk("t2_load", bus.imemload, 32'h3C01_0001);

      // Conflict at index 1: 0x04 / 0x44 evict each other
      do_fill(32'h0000_0004, 32'hAAAA_0001, 0);
      do_fill(32'h0000_0044, 32'hBBBB_0002, 1);
      do_fill(32'h0000_0004, 32'hAAAA_0001, 0);
      chk("t3_miss", bus.miss_count, 32'd4);
      chk("t3_hits", bus.hit_count, 32'd3);
      chk("t3_load", bus.imemload, 32'hAAAA_0001);

      // imemREN dropped mid-fill at 0x10: the fill still completes
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0010;
      #1;
      chk("t5_ihit0", {31'd0, bus.ihit}, 32'd0);
      cyc();
      bus.imemREN  = 1'b0;
      bus.imemaddr = 32'h0000_0080;
      #1;
      chk("t5_iREN_a", {31'd0, bus.iREN}, 32'd1);
      chk("t5_iaddr", bus.iaddr, 32'h0000_0010);
      cyc();
      bus.iwait = 1'b0;
      bus.iload = 32'hDEAD_0010;
      #1;
      chk("t5_iREN_b", {31'd0, bus.iREN}, 32'd1);
      cyc();
      bus.iwait = 1'b1;
      #1;
      chk("t5_iREN_c", {31'd0, bus.iREN}, 32'd0);
      chk("t5_idle_hit", {31'd0, bus.ihit}, 32'd0);
      chk("t5_idle_load", bus.imemload, 32'd0);
      cyc();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0010;
      #1;
      chk("t5_ihit1", {31'd0, bus.ihit}, 32'd1);
      chk("t5_load", bus.imemload, 32'hDEAD_0010);
      chk("t5_iREN_d", {31'd0, bus.iREN}, 32'd0);
      cyc();
      chk("t5_hits", bus.hit_count, 32'd4);
      chk("t5_miss", bus.miss_count, 32'd5);

      // Reset pulsed during a fill of 0x20
      bus.imemaddr = 32'h0000_0020;
      #1;
      chk("t6_miss_ihit", {31'd0, bus.ihit}, 32'd0);
      cyc();
      #1;
      chk("t6_iREN_a", {31'd0, bus.iREN}, 32'd1);
      #1 nRST = 1'b0;
      #1;
      chk("t6_iREN_b", {31'd0, bus.iREN}, 32'd0);
      chk("t6_hits", bus.hit_count, 32'd0);
      chk("t6_miss", bus.miss_count, 32'd0);
      chk("t6_iaddr", bus.iaddr, 32'd0);
      bus.iwait = 1'b0;
      bus.iload = 32'h1234_5678;
      cyc();
      nRST      = 1'b1;
      bus.iwait = 1'b1;
      bus.imemaddr = 32'h0000_0000;
      #1;
      chk("t6_old0", {31'd0, bus.ihit}, 32'd0);
      bus.imemaddr = 32'h0000_0010;
      #1;
      chk("t6_old10", {31'd0, bus.ihit}, 32'd0);
      bus.imemaddr = 32'h0000_0020;
      #1;
      chk("t6_late", {31'd0, bus.ihit}, 32'd0);
      bus.imemREN = 1'b0;
      cyc();
      #1;
      chk("t6_idle_iREN", {31'd0, bus.iREN}, 32'd0);

      // Sequential pass 0x00..0x3C, then a second all-hit pass
      for (int unsigned i = 0; i < 16; i++) begin
         do_fill(i * 4, 32'hC0DE_0000 + i, 0);
         cyc();
      end
      for (int unsigned i = 0; i < 16; i++) begin
         bus.imemaddr = i * 4;
         #1;
         chk("t4_ihit", {31'd0, bus.ihit}, 32'd1);
         chk("t4_load", bus.imemload, 32'hC0DE_0000 + i);
         chk("t4_iREN", {31'd0, bus.iREN}, 32'd0);
         cyc();
      end
      bus.imemREN = 1'b0;
      #1;
      chk("t4_hits", bus.hit_count, 32'd32);
      chk("t4_miss", bus.miss_count, 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
